// File: rtl/sram_wr_sched.sv
// sram_wr_sched: four-requester write scheduler for a dual-write-port SRAM.
//
// After reset, a clear sweep writes zero to every SRAM entry, two entries per
// cycle. After the sweep, up to two of four requesters are granted each cycle
// in round-robin order. The grants drive the registered SRAM write ports.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   reqN_valid_i/addr_i/data_i requester N write request (N=0..3)
//   reqN_ready_o               grant to requester N (combinational)
//   weM_o/addrMwr_o/dataMwr_o  SRAM write port M (M=0,1), registered
//   init_busy_o                high while the clear sweep runs
//
// state | meaning
// INIT  | clear sweep, zero written to entries 2k and 2k+1 each cycle
// RUN   | round-robin arbitration, at most two grants per cycle
module sram_wr_sched #(
  parameter int SRAM_DEPTH = 16,
  parameter int SRAM_INDEX = 4,
  parameter int SRAM_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid_i,
  input  logic [SRAM_INDEX-1:0] req0_addr_i,
  input  logic [SRAM_WIDTH-1:0] req0_data_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic [SRAM_INDEX-1:0] req1_addr_i,
  input  logic [SRAM_WIDTH-1:0] req1_data_i,
  output logic                  req1_ready_o,
  input  logic                  req2_valid_i,
  input  logic [SRAM_INDEX-1:0] req2_addr_i,
  input  logic [SRAM_WIDTH-1:0] req2_data_i,
  output logic                  req2_ready_o,
  input  logic                  req3_valid_i,
  input  logic [SRAM_INDEX-1:0] req3_addr_i,
  input  logic [SRAM_WIDTH-1:0] req3_data_i,
  output logic                  req3_ready_o,
  output logic                  we0_o,
  output logic [SRAM_INDEX-1:0] addr0wr_o,
  output logic [SRAM_WIDTH-1:0] data0wr_o,
  output logic                  we1_o,
  output logic [SRAM_INDEX-1:0] addr1wr_o,
  output logic [SRAM_WIDTH-1:0] data1wr_o,
  output logic                  init_busy_o
);

  localparam int HALF = SRAM_DEPTH / 2;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state, state_nxt;
  logic [SRAM_INDEX-2:0]   sweep_k, sweep_k_nxt;
  logic [1:0]              rr_ptr, rr_ptr_nxt;

  logic [3:0]              valid;
  logic [SRAM_INDEX-1:0]   addr [4];
  logic [SRAM_WIDTH-1:0]   data [4];
  logic [3:0]              ready;

  logic                    g0_v, g1_v;
  logic [SRAM_INDEX-1:0]   g0_addr, g1_addr;
  logic [SRAM_WIDTH-1:0]   g0_data, g1_data;
  logic [1:0]              idx;

  assign valid   = {req3_valid_i, req2_valid_i, req1_valid_i, req0_valid_i};
  assign addr[0] = req0_addr_i;
  assign addr[1] = req1_addr_i;
  assign addr[2] = req2_addr_i;
  assign addr[3] = req3_addr_i;
  assign data[0] = req0_data_i;
  assign data[1] = req1_data_i;
  assign data[2] = req2_data_i;
  assign data[3] = req3_data_i;

  assign req0_ready_o = ready[0];
  assign req1_ready_o = ready[1];
  assign req2_ready_o = ready[2];
  assign req3_ready_o = ready[3];

  assign init_busy_o = (state == INIT);

  always_comb begin
    state_nxt   = state;
    sweep_k_nxt = sweep_k;
    rr_ptr_nxt  = rr_ptr;
    ready       = '0;
    g0_v        = 1'b0;
    g1_v        = 1'b0;
    g0_addr     = '0;
    g1_addr     = '0;
    g0_data     = '0;
    g1_data     = '0;
    idx         = '0;
    case (state)
      INIT: begin
        g0_v    = 1'b1;
        g1_v    = 1'b1;
        g0_addr = {sweep_k, 1'b0};
        g1_addr = {sweep_k, 1'b1};
        if (sweep_k == (SRAM_INDEX-1)'(HALF - 1)) begin
          state_nxt   = RUN;
          sweep_k_nxt = '0;
        end else begin
          sweep_k_nxt = sweep_k + (SRAM_INDEX-1)'(1);
        end
      end
      RUN: begin
        for (int i = 0; i < 4; i++) begin
          idx = rr_ptr + 2'(i);
          if (valid[idx] && !g1_v) begin
            if (!g0_v) begin
              g0_v       = 1'b1;
              g0_addr    = addr[idx];
              g0_data    = data[idx];
              ready[idx] = 1'b1;
              rr_ptr_nxt = idx + 2'd1;
            end else if (addr[idx] != g0_addr) begin
              // same-address candidate is skipped so both ports never collide
              g1_v       = 1'b1;
              g1_addr    = addr[idx];
              g1_data    = data[idx];
              ready[idx] = 1'b1;
              rr_ptr_nxt = idx + 2'd1;
            end
          end
        end
      end
      default: state_nxt = INIT;
    endcase
    // a reset cycle must not report a transfer that will never be written
    if (reset) ready = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      sweep_k   <= '0;
      rr_ptr    <= '0;
      we0_o     <= 1'b0;
      we1_o     <= 1'b0;
      addr0wr_o <= '0;
      addr1wr_o <= '0;
      data0wr_o <= '0;
      data1wr_o <= '0;
    end else begin
      state   <= state_nxt;
      sweep_k <= sweep_k_nxt;
      rr_ptr  <= rr_ptr_nxt;
      we0_o   <= g0_v;
      we1_o   <= g1_v;
      if (g0_v) begin
        addr0wr_o <= g0_addr;
        data0wr_o <= g0_data;
      end
      if (g1_v) begin
        addr1wr_o <= g1_addr;
        data1wr_o <= g1_data;
      end
    end
  end

endmodule

// File: doc/sram_wr_sched.md
SRAM_WR_SCHED -- requirements
Module: sram_wr_sched

Interface
REQ-001 SHALL have parameter SRAM_DEPTH, default 16: number of SRAM entries; even, at least 4.
REQ-002 SHALL have parameter SRAM_INDEX, default 4: address width; log2(SRAM_DEPTH).
REQ-003 SHALL have parameter SRAM_WIDTH, default 8: data width.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports reqN_valid_i  input  1  (N=0..3)  requester N has a pending write.
REQ-007 SHALL have ports reqN_addr_i  input  SRAM_INDEX  (N=0..3)  write address of requester N.
REQ-008 SHALL have ports reqN_data_i  input  SRAM_WIDTH  (N=0..3)  write data of requester N.
REQ-009 SHALL have ports reqN_ready_o  output  1  (N=0..3)  grant; transfer occurs when valid and ready are both 1.
REQ-010 SHALL have ports weM_o  output  1  (M=0,1)  SRAM write-port M enable.
REQ-011 SHALL have ports addrMwr_o  output  SRAM_INDEX  (M=0,1)  SRAM write-port M address.
REQ-012 SHALL have ports dataMwr_o  output  SRAM_WIDTH  (M=0,1)  SRAM write-port M data.
REQ-013 SHALL have port init_busy_o  output  1  high while the clear sweep runs.

Function
REQ-014 SHALL implement a two-state FSM: INIT (clear sweep) and RUN (arbitration).
REQ-015 INIT SHALL keep a sweep counter k, running 0..SRAM_DEPTH/2-1, and issue writes of zero to addresses 2k (port 0) and 2k+1 (port 1) each cycle.
REQ-016 INIT SHALL move to RUN in the cycle after the sweep write for k=SRAM_DEPTH/2-1 is issued; the sweep takes exactly SRAM_DEPTH/2 cycles.
REQ-017 init_busy_o SHALL be 1 in INIT and 0 in RUN.
REQ-018 All reqN_ready_o SHALL be 0 in INIT.
REQ-019 In RUN, ready SHALL be combinational from the current valids, addresses and the round-robin pointer p (2 bits).
REQ-020 RUN SHALL scan requesters in order p, p+1, p+2, p+3 (mod 4) and grant at most two valid requesters per cycle.
REQ-021 The first grant found in scan order SHALL map to write port 0 and the second to port 1.
REQ-022 A second candidate whose address equals the first grant's address SHALL be skipped that cycle; the scan SHALL continue to the next requester.
REQ-023 Outputs weM_o, addrMwr_o and dataMwr_o SHALL be registered: a transfer in cycle t appears on the port in cycle t+1 for exactly one cycle.
REQ-024 An unused port SHALL drive weM_o=0; its address and data SHALL hold their previous values.
REQ-025 After a cycle with at least one grant, p SHALL become (index of last granted requester + 1) mod 4; with no grant, p SHALL be unchanged.
REQ-026 A requester SHALL hold valid, addr and data stable until its transfer; an ungranted valid SHALL be retained and re-arbitrated each cycle.
REQ-027 The two ports SHALL never carry the same address with both enables high in the same cycle.

Reset
REQ-028 When reset=1 at a clock edge, the block SHALL set FSM=INIT, k=0, p=0, we0_o=we1_o=0, addr/data outputs to 0, and init_busy_o=1.
REQ-029 The first sweep write (addresses 0 and 1) SHALL appear in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-sweep or mid-RUN SHALL abort the current activity immediately, drop any grant in that cycle, and restart the sweep from k=0.

Verification
REQ-031 Reset for 1 cycle, SRAM_DEPTH=16 -> init_busy_o=1 for 8 cycles; port pairs (0,1), (2,3) ... (14,15) written with data 0; RUN in cycle 9; all ready_o=0 throughout the sweep.
REQ-032 RUN, p=0, all four valid with distinct addresses -> cycle 1: req0 to port 0 and req1 to port 1, p=2; cycle 2: req2 and req3 granted, p=0; each write appears one cycle after its grant.
REQ-033 RUN, p=0, req0 and req1 both addr 5 and req2 addr 7 -> req0 to port 0 and req2 to port 1; req1 is granted next cycle to port 0.
REQ-034 Only req3 valid, p=1 -> req3 granted on port 0, we1_o=0 next cycle, p=0.
REQ-035 Reset asserted during sweep k=3 -> next cycle: we outputs 0 and k=0; the sweep restarts at addresses 0 and 1 and takes the full 8 cycles.
REQ-036 No valid requests for 5 cycles in RUN -> we0_o=we1_o=0 and p unchanged throughout.
